pin_array_lane_seq: RTL and testbench
=====================================

// Module: pin_array_lane_seq
// PURPOSE
//   Sequencer for the pin_array lane bank: NLANE 1-bit lane cells drive the shared mid bus into the aggregator cell.
//   - Staggers lane power-up one lane per SETTLE_CYC cycles to limit inrush.
//   - Waits a final settle interval, then repeatedly captures mid into a word.
//   - Delivers each word downstream with a valid/ready handshake.
//   - Ramps the bank down on request.
// PARAMETERS
//   NLANE       4  number of lane cells / width of mid and data
//   SETTLE_CYC  8  cycles between successive lane enables and before first sample; legal range >=1
//   CNT_W       $clog2(SETTLE_CYC+1)  settle counter width (derived, not overridden)
// PORTS
//   clk       in   1      single clock, rising edge
//   rst       in   1      synchronous reset, active-high
//   start     in   1      begin power-up; sampled in IDLE only
//   stop      in   1      request power-down; sticky until honoured
//   lane_en   out  NLANE  per-lane enable to lane cells; lane 0 first
//   mid       in   NLANE  lane outputs (shared bus into aggregator)
//   data      out  NLANE  captured mid word
//   valid     out  1      data valid
//   ready     in   1      downstream accepts data when valid&ready
//   busy      out  1      high whenever state != IDLE
// BEHAVIOUR
//   - Reset: state=IDLE, lane_en=0, data=0, valid=0, busy=0, lane index=0, counter=0, stop_pend=0.
//   - States: IDLE -> RAMP -> SETTLE -> SAMPLE -> HOLD -> (SAMPLE | DOWN); DOWN -> IDLE.
//   - IDLE, start=1 at cycle 0:
//       lane_en[0]=1 and busy=1 at cycle 1.
//       lane_en[k] set at cycle 1+k*SETTLE_CYC; enables accumulate (thermometer) and never drop mid-ramp.
//   - SETTLE: after the last lane, count SETTLE_CYC cycles.
//       SAMPLE captures mid at cycle 1+NLANE*SETTLE_CYC.
//       valid=1 one cycle later (HOLD).
//   - HOLD: data and valid held stable while ready=0.
//       Handshake (valid&ready) at cycle t: valid=0 at t+1 and mid recaptured at t+1.
//       valid=1 at t+2; throughput is one word per 2 cycles.
//   - stop: latched into stop_pend whenever busy; stop in IDLE is ignored.
//       Pending in RAMP/SETTLE: next cycle is DOWN.
//       Pending in HOLD: honoured only after the current word's handshake, so a valid word is never dropped.
//       Pending in SAMPLE: the word completes first.
//   - DOWN (1 cycle): lane_en=0, valid=0, stop_pend cleared, index/counter cleared; IDLE next cycle, busy=0.
//   - start while busy: ignored.
//   - start and stop in the same cycle in IDLE: start wins; the stop is dropped because it is not busy.
//   - rst mid-operation: all outputs return to reset values in the following cycle regardless of state; no DOWN cycle.
//   - SETTLE_CYC=1: lanes enable on consecutive cycles.
//   - Counter never wraps; it is reloaded on each lane step.
// CONFIGURATION
//   PIN_ARRAY_LANE_SEQ_PARITY_EN
//     defined:   adds output data_par (1 bit) = ^mid captured in the same cycle as data; reset 0; held with data in HOLD.
//     undefined: port absent; behaviour otherwise identical.
// TESTING
//   1. NLANE=4, SETTLE_CYC=8, start pulse @0, ready=1, mid=4'b1010:
//      lane_en 0001@1, 0011@9, 0111@17, 1111@25; data=1010, valid=1 @34.
//   2. Backpressure: ready=0 for 10 cycles while valid; change mid to 0101 meanwhile:
//      data stays 1010 and valid stays high; ready=1 -> valid low next cycle, data=0101, valid=1 two cycles after handshake.
//   3. stop at cycle 12 (mid-ramp): lane_en=0011 through 12, DOWN @13 (lane_en=0), busy=0 @14; a start @20 restarts from lane 0.
//   4. stop while HOLD with ready=0: no drop; on later handshake next cycle DOWN, lane_en=0, valid=0, then IDLE.
//   5. rst asserted @30 during SETTLE: @31 lane_en=0, valid=0, busy=0, data=0; start@0 and stop@0 simultaneously -> ramp proceeds.
//   6. Macro defined, mid=4'b0111: data_par=1 with valid; mid=4'b0110 -> data_par=0.

Source files
------------

// File: rtl/pin_array_lane_seq.sv
// Lane bank sequencer: staggers lane power-up, settles, then streams captured mid words over valid/ready.
// Optional build macro PIN_ARRAY_LANE_SEQ_PARITY_EN adds data_par (parity of each captured word).
module pin_array_lane_seq #(
   parameter  int NLANE      = 4,
   parameter  int SETTLE_CYC = 8,
   localparam int CNT_W      = $clog2(SETTLE_CYC + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   output logic [NLANE-1:0] lane_en,
   input  logic [NLANE-1:0] mid,
   output logic [NLANE-1:0] data,
   output logic             valid,
   input  logic             ready,
   output logic             busy
`ifdef PIN_ARRAY_LANE_SEQ_PARITY_EN
   ,
   output logic             data_par
`endif
);

   typedef enum logic [2:0] {
      IDLE,
      RAMP,
      SETTLE,
      SAMPLE,
      HOLD,
      DOWN
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

   state_t           state_q, state_d;
   logic [NLANE-1:0] lane_en_q, lane_en_d;
   logic [NLANE-1:0] data_q, data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stop_pend_q, stop_pend_d;
   logic             par_q, par_d;
   logic             stop_now;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         lane_en_q   <= '0;
         data_q      <= '0;
         cnt_q       <= '0;
         stop_pend_q <= 1'b0;
         par_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         lane_en_q   <= lane_en_d;
         data_q      <= data_d;
         cnt_q       <= cnt_d;
         stop_pend_q <= stop_pend_d;
         par_q       <= par_d;
      end
   end

   // The enable vector doubles as the lane index: ramp ends once it is all ones.
   always_comb begin
      state_d     = state_q;
      lane_en_d   = lane_en_q;
      data_d      = data_q;
      cnt_d       = cnt_q;
      stop_pend_d = stop_pend_q;
      par_d       = par_q;
      stop_now    = stop | stop_pend_q;

      if (state_q != IDLE && stop) begin
         stop_pend_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               lane_en_d = NLANE'(1);
               cnt_d     = '0;
               state_d   = (&lane_en_d) ? SETTLE : RAMP;
            end
         end
         RAMP: begin
            if (stop_now) begin
               lane_en_d = '0;
               state_d   = DOWN;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d     = '0;
               lane_en_d = (lane_en_q << 1) | NLANE'(1);
               state_d   = (&lane_en_d) ? SETTLE : RAMP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         SETTLE: begin
            if (stop_now) begin
               lane_en_d = '0;
               state_d   = DOWN;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = SAMPLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         SAMPLE: begin
            data_d  = mid;
            par_d   = ^mid;
            state_d = HOLD;
         end
         HOLD: begin
            // A pending stop waits for the handshake so the presented word is never lost.
            if (ready) begin
               if (stop_now) begin
                  lane_en_d = '0;
                  state_d   = DOWN;
               end else begin
                  state_d = SAMPLE;
               end
            end
         end
         DOWN: begin
            lane_en_d   = '0;
            cnt_d       = '0;
            stop_pend_d = 1'b0;
            state_d     = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign lane_en = lane_en_q;
   assign data    = data_q;
   assign valid   = (state_q == HOLD);
   assign busy    = (state_q != IDLE);

`ifdef PIN_ARRAY_LANE_SEQ_PARITY_EN
   assign data_par = par_q;
`else
   logic unusedPar;
   assign unusedPar = par_q;
`endif

endmodule

// File: tb/tb_pin_array_lane_seq.sv
// Directed bench for pin_array_lane_seq: ramp timing, backpressure, stop/reset handling, word scoreboard.
module tb_pin_array_lane_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       stop;
   logic [3:0] lane_en;
   logic [3:0] mid;
   logic [3:0] data;
   logic       valid;
   logic       ready;
   logic       busy;
`ifdef PIN_ARRAY_LANE_SEQ_PARITY_EN
   logic       data_par;
`endif

   typedef struct {
      logic [3:0] word;
      logic       par;
   } exp_t;

   exp_t sbQ[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   pin_array_lane_seq #(.NLANE(4), .SETTLE_CYC(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .stop    (stop),
      .lane_en (lane_en),
      .mid     (mid),
      .data    (data),
      .valid   (valid),
      .ready   (ready),
      .busy    (busy)
`ifdef PIN_ARRAY_LANE_SEQ_PARITY_EN
      ,
      .data_par(data_par)
`endif
   );

   always #5 clk = ~clk;

   task automatic applyStimulus(input logic st, input logic sp, input logic rd, input logic [3:0] m);
      start = st;
      stop  = sp;
      ready = rd;
      mid   = m;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic pushWord(input logic [3:0] w);
      exp_t e;
      e.word = w;
      e.par  = ^w;
      sbQ.push_back(e);
   endtask

   function automatic logic [3:0] therm(input int n);
      logic [4:0] t;
      t = (5'd1 << n) - 5'd1;
      return t[3:0];
   endfunction

   // Monitor: every accepted word must match the oldest expectation in the scoreboard.
   always @(negedge clk) begin
      if (!rst && valid && ready) begin
         checks++;
         if (sbQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_word: got %0h with no expectation queued", data);
         end else begin
            exp_t e;
            e = sbQ.pop_front();
            if (data !== e.word) begin
               errors++;
               $display("[TB] FAIL sb_data: got %0h expected %0h", data, e.word);
            end
`ifdef PIN_ARRAY_LANE_SEQ_PARITY_EN
            checks++;
            if (data_par !== e.par) begin
               errors++;
               $display("[TB] FAIL sb_par: got %0b expected %0b", data_par, e.par);
            end
`endif
         end
      end
   end

   initial begin
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
      tick();
      tick();
      rst = 1'b0;
      checkOutput("rst_lane_en", 32'(lane_en), 32'h0);
      checkOutput("rst_valid", 32'(valid), 32'h0);
      checkOutput("rst_busy", 32'(busy), 32'h0);
      checkOutput("rst_data", 32'(data), 32'h0);

      // Start and stop together in IDLE: start wins, ramp proceeds.
      cyc = 0;
      applyStimulus(1'b1, 1'b1, 1'b0, 4'b1010);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 4'b1010);
      checkOutput("busy_at_1", 32'(busy), 32'h1);
      for (int c = 1; c <= 33; c++) begin
         int n;
         n = (c - 1) / 8 + 1;
         if (n > 4) n = 4;
         checkOutput("ramp_lane_en", 32'(lane_en), 32'(therm(n)));
         checkOutput("ramp_valid", 32'(valid), 32'h0);
         tick();
      end
      checkOutput("first_valid", 32'(valid), 32'h1);
      checkOutput("first_data", 32'(data), 32'ha);

      // Backpressure: word holds while mid changes underneath.
      applyStimulus(1'b0, 1'b0, 1'b0, 4'b0101);
      for (int i = 0; i < 10; i++) begin
         tick();
         checkOutput("bp_valid", 32'(valid), 32'h1);
         checkOutput("bp_data", 32'(data), 32'ha);
      end
      pushWord(4'b1010);
      applyStimulus(1'b0, 1'b0, 1'b1, 4'b0101);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 4'b0101);
      checkOutput("post_hs_valid", 32'(valid), 32'h0);
      tick();
      checkOutput("recap_valid", 32'(valid), 32'h1);
      checkOutput("recap_data", 32'(data), 32'h5);

      // Stop while holding with ready low: word stays until handshake, then DOWN.
      applyStimulus(1'b0, 1'b1, 1'b0, 4'b0101);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 4'b0101);
      for (int i = 0; i < 3; i++) begin
         checkOutput("stop_hold_valid", 32'(valid), 32'h1);
         checkOutput("stop_hold_lanes", 32'(lane_en), 32'hf);
         tick();
      end
      pushWord(4'b0101);
      applyStimulus(1'b0, 1'b0, 1'b1, 4'b0101);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 4'b0101);
      checkOutput("down_lane_en", 32'(lane_en), 32'h0);
      checkOutput("down_valid", 32'(valid), 32'h0);
      checkOutput("down_busy", 32'(busy), 32'h1);
      tick();
      checkOutput("idle_busy", 32'(busy), 32'h0);

      // Stop mid-ramp at cycle 12.
      cyc = 0;
      applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
      checkOutput("r2_lane_en_1", 32'(lane_en), 32'h1);
      while (cyc < 12) tick();
      checkOutput("r2_lane_en_12", 32'(lane_en), 32'h3);
      applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
      checkOutput("r2_down_lanes", 32'(lane_en), 32'h0);
      checkOutput("r2_down_busy", 32'(busy), 32'h1);
      tick();
      checkOutput("r2_idle_busy", 32'(busy), 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
      checkOutput("idle_stop_ignored", 32'(busy), 32'h0);
      while (cyc < 20) tick();

      // Restart from lane 0, then reset in SETTLE.
      cyc = 0;
      applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
      checkOutput("restart_lanes", 32'(lane_en), 32'h1);
      tick();
      checkOutput("restart_lanes_2", 32'(lane_en), 32'h1);
      checkOutput("restart_busy", 32'(busy), 32'h1);
      while (cyc < 30) tick();
      checkOutput("settle_lanes", 32'(lane_en), 32'hf);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("mid_rst_lanes", 32'(lane_en), 32'h0);
      checkOutput("mid_rst_valid", 32'(valid), 32'h0);
      checkOutput("mid_rst_busy", 32'(busy), 32'h0);
      checkOutput("mid_rst_data", 32'(data), 32'h0);

      // Two more words with odd and even parity.
      cyc = 0;
      applyStimulus(1'b1, 1'b0, 1'b0, 4'b0111);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 4'b0111);
      while (cyc < 34) tick();
      checkOutput("p_valid", 32'(valid), 32'h1);
      checkOutput("p_data", 32'(data), 32'h7);
`ifdef PIN_ARRAY_LANE_SEQ_PARITY_EN
      checkOutput("p_par_odd", 32'(data_par), 32'h1);
`endif
      pushWord(4'b0111);
      applyStimulus(1'b0, 1'b0, 1'b1, 4'b0110);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 4'b0110);
      checkOutput("p_gap_valid", 32'(valid), 32'h0);
      tick();
      checkOutput("p2_valid", 32'(valid), 32'h1);
      checkOutput("p2_data", 32'(data), 32'h6);
`ifdef PIN_ARRAY_LANE_SEQ_PARITY_EN
      checkOutput("p_par_even", 32'(data_par), 32'h0);
`endif
      pushWord(4'b0110);
      applyStimulus(1'b0, 1'b0, 1'b1, 4'b0110);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 4'b0110);
      tick();
      tick();
      checkOutput("sb_drained", 32'(sbQ.size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
